// File: rtl/audio_adc_deserializer.sv
// rtl/audio_adc_deserializer.sv - I2S ADC receiver: bit-clock sync, word framing, sample-pair FIFO
module audio_adc_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_ADCLRCK,
  input  logic                          AUD_ADCDAT,
  input  logic                          clear_audio_in_memory,
  input  logic                          read_audio_in,
  output logic                          audio_in_available,
  output logic [DATA_WIDTH-1:0]         left_channel_audio_in,
  output logic [DATA_WIDTH-1:0]         right_channel_audio_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int BW   = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {ALIGN, SKIP, SHIFT, HOLD} state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_prev_q;
  logic lrck_s1_q, lrck_s2_q, lrck_last_q;
  logic dat_s1_q, dat_s2_q;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [BW-1:0]           cnt_q;
  logic                    word_ch_q;
  logic [DATA_WIDTH-1:0]   left_hold_q;
  logic                    push_q;
  logic [2*DATA_WIDTH-1:0] push_pair_q;

  logic                    bclk_rise, lr_edge;
  logic [DATA_WIDTH-1:0]   shift_d;
  logic                    commit_en;
  logic [DATA_WIDTH-1:0]   commit_word;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      dat_s1_q    <= 1'b0;
      dat_s2_q    <= 1'b0;
    end else begin
      bclk_s1_q   <= AUD_BCLK;
      bclk_s2_q   <= bclk_s1_q;
      bclk_prev_q <= bclk_s2_q;
      lrck_s1_q   <= AUD_ADCLRCK;
      lrck_s2_q   <= lrck_s1_q;
      dat_s1_q    <= AUD_ADCDAT;
      dat_s2_q    <= dat_s1_q;
    end
  end

  assign bclk_rise = bclk_s2_q & ~bclk_prev_q;
  assign lr_edge   = bclk_rise & (lrck_s2_q != lrck_last_q);

  // A word cut short by an LR edge is committed left-aligned, LSBs zero.
  always_comb begin
    shift_d     = {shift_q[DATA_WIDTH-2:0], dat_s2_q};
    commit_en   = 1'b0;
    commit_word = shift_d;
    if (bclk_rise && state_q == SHIFT) begin
      if (lr_edge) begin
        commit_en   = 1'b1;
        commit_word = shift_q << (DATA_WIDTH - int'(cnt_q));
      end else if (cnt_q == BW'(DATA_WIDTH - 1)) begin
        commit_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ALIGN;
      shift_q     <= '0;
      cnt_q       <= '0;
      word_ch_q   <= 1'b0;
      lrck_last_q <= 1'b0;
      left_hold_q <= '0;
      push_q      <= 1'b0;
      push_pair_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (bclk_rise) begin
        lrck_last_q <= lrck_s2_q;
        case (state_q)
          ALIGN: if (lr_edge && !lrck_s2_q) begin
            word_ch_q <= 1'b0;
            state_q   <= SKIP;
          end
          SKIP: begin
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
          SHIFT: if (lr_edge) begin
            word_ch_q <= lrck_s2_q;
            state_q   <= SKIP;
          end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + BW'(1);
            if (cnt_q == BW'(DATA_WIDTH - 1)) state_q <= HOLD;
          end
          HOLD: if (lr_edge) begin
            word_ch_q <= lrck_s2_q;
            state_q   <= SKIP;
          end
          default: state_q <= ALIGN;
        endcase
      end
      if (commit_en) begin
        if (word_ch_q) begin
          push_q      <= 1'b1;
          push_pair_q <= {left_hold_q, commit_word};
        end else begin
          left_hold_q <= commit_word;
        end
      end
    end
  end

  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]         count_q;
  logic                    ovf_q;
  logic [2*DATA_WIDTH-1:0] last_q;
  logic                    pop, push_ok, not_empty;

  assign not_empty = (count_q != '0);
  assign pop       = read_audio_in & not_empty;
  assign push_ok   = push_q & ((count_q != CNTW'(FIFO_DEPTH)) | pop);

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_pair_q;
  end

  // last_q keeps the outputs steady on the most recently popped pair while empty.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear_audio_in_memory) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
      if (push_q && !push_ok) ovf_q <= 1'b1;
    end
  end

  logic [2*DATA_WIDTH-1:0] head;
  assign head = not_empty ? mem_q[rd_ptr_q] : last_q;

  assign audio_in_available     = not_empty;
  assign left_channel_audio_in  = head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign right_channel_audio_in = head[DATA_WIDTH-1:0];
  assign fifo_count             = count_q;
  assign overflow               = ovf_q;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// tb/tb_audio_adc_deserializer.sv - scoreboard bench for audio_adc_deserializer
module tb_audio_adc_deserializer;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic CLOCK_50 = 1'b0;
  logic reset, AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;
  logic clear_audio_in_memory, read_audio_in;
  logic audio_in_available, overflow;
  logic [DW-1:0] left_channel_audio_in, right_channel_audio_in;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_adc_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .AUD_BCLK(AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT),
    .clear_audio_in_memory(clear_audio_in_memory),
    .read_audio_in(read_audio_in),
    .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_channel_audio_in),
    .right_channel_audio_in(right_channel_audio_in),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  logic [63:0] exp_q[$];
  logic [63:0] last_pair;
  logic        exp_ovf;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One BCLK period of 16 CLOCK_50 cycles; pins change while BCLK is low.
  task automatic send_bit(input logic lr, input logic d, input bit pop_here);
    logic [63:0] e;
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    repeat (8) @(negedge CLOCK_50);
    AUD_BCLK = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLOCK_50);
      if (pop_here && i == 3) begin
        check("full_pop_avail", {63'd0, audio_in_available}, 64'd1);
        e = exp_q.pop_front();
        check("full_pop_data", {left_channel_audio_in, right_channel_audio_in}, e);
        last_pair = e;
        read_audio_in = 1'b1;
      end
      if (pop_here && i == 4) read_audio_in = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nl,
                            input bit pop_at_push, input int rst_at);
    bit accept;
    int nlslot;
    logic b;
    accept = (exp_q.size() < DEPTH) || pop_at_push;
    nlslot = (nl == 32) ? 36 : nl + 2;
    for (int j = 0; j < nlslot; j++) begin
      if (j == rst_at) reset = 1'b0;
      b = (j >= 2 && j < nl + 2) ? l[33 - j] : 1'b0;
      send_bit(1'b0, b, 1'b0);
    end
    for (int j = 0; j < 36; j++) begin
      b = (j >= 2 && j < 34) ? r[33 - j] : 1'b0;
      send_bit(1'b1, b, pop_at_push && (j == 33));
    end
    if (rst_at < 0) begin
      if (accept) exp_q.push_back({l, r});
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic do_read(input string tag);
    int t;
    logic [63:0] e;
    t = 0;
    if (exp_q.size() == 0) begin
      check({tag, "_spurious"}, {63'd0, audio_in_available}, 64'd0);
    end else begin
      while (!audio_in_available && t < 2000) begin
        @(negedge CLOCK_50);
        t++;
      end
      check({tag, "_avail"}, {63'd0, audio_in_available}, 64'd1);
      e = exp_q.pop_front();
      check({tag, "_data"}, {left_channel_audio_in, right_channel_audio_in}, e);
      last_pair = e;
      read_audio_in = 1'b1;
      @(negedge CLOCK_50);
      read_audio_in = 1'b0;
      check({tag, "_count"}, 64'(fifo_count), 64'(exp_q.size()));
    end
  endtask

  initial begin
    repeat (200000) @(posedge CLOCK_50);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    AUD_BCLK = 1'b0;
    AUD_ADCLRCK = 1'b0;
    AUD_ADCDAT = 1'b0;
    clear_audio_in_memory = 1'b0;
    read_audio_in = 1'b0;
    exp_ovf = 1'b0;
    last_pair = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      AUD_BCLK    = ~AUD_BCLK;
      AUD_ADCLRCK = 1'($urandom);
      AUD_ADCDAT  = 1'($urandom);
    end
    @(negedge CLOCK_50);
    check("rst_avail", {63'd0, audio_in_available}, 64'd0);
    check("rst_left", 64'(left_channel_audio_in), 64'd0);
    check("rst_right", 64'(right_channel_audio_in), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);

    reset = 1'b0;
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);

    send_frame(32'h8000_0001, 32'h7FFF_FFFE, 32, 1'b0, -1);
    check("one_avail", {63'd0, audio_in_available}, 64'd1);
    check("one_count", 64'(fifo_count), 64'd1);
    do_read("one");
    check("one_empty", {63'd0, audio_in_available}, 64'd0);
    check("one_hold", {left_channel_audio_in, right_channel_audio_in}, last_pair);

    reset = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    last_pair = '0;
    send_frame(32'hAAAA_5555, 32'h5555_AAAA, 32, 1'b0, 12);
    send_frame(32'hB0B0_0001, 32'hB1B1_0002, 32, 1'b0, -1);
    send_frame(32'hC0C0_0003, 32'hC1C1_0004, 32, 1'b0, -1);
    check("midrst_count", 64'(fifo_count), 64'(exp_q.size()));
    do_read("midrst_b");
    do_read("midrst_c");
    do_read("midrst_none");

    for (int k = 1; k <= 9; k++)
      send_frame(32'h1000_0000 + 32'(k), 32'hF000_0000 - 32'(k * 3), 32, 1'b0, -1);
    check("ovf_count", 64'(fifo_count), 64'(DEPTH));
    check("ovf_flag", {63'd0, overflow}, {63'd0, exp_ovf});
    for (int k = 0; k < DEPTH; k++) do_read("ovf_rd");
    check("ovf_sticky", {63'd0, overflow}, {63'd0, exp_ovf});
    clear_audio_in_memory = 1'b1;
    @(negedge CLOCK_50);
    clear_audio_in_memory = 1'b0;
    exp_ovf = 1'b0;
    last_pair = '0;
    check("clr_count", 64'(fifo_count), 64'd0);
    check("clr_ovf", {63'd0, overflow}, 64'd0);
    check("clr_out", {left_channel_audio_in, right_channel_audio_in}, last_pair);

    for (int k = 0; k < DEPTH; k++)
      send_frame(32'h0123_0000 ^ 32'($urandom), 32'($urandom), 32, 1'b0, -1);
    send_frame(32'hFEED_0008, 32'hBEEF_0009, 32, 1'b1, -1);
    check("pp_count", 64'(fifo_count), 64'(DEPTH));
    check("pp_ovf", {63'd0, overflow}, {63'd0, exp_ovf});
    for (int k = 0; k < DEPTH; k++) do_read("pp_rd");

    send_frame(32'hABCD_0000, 32'h1234_5678, 16, 1'b0, -1);
    send_frame(32'h0F0F_F0F0, 32'hC3C3_3C3C, 32, 1'b0, -1);
    do_read("short_rd");
    do_read("short_next");
    check("hold_last", {left_channel_audio_in, right_channel_audio_in}, last_pair);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
